conway_grid_serial: RTL
=======================

# conway_grid_serial

Parametrised Game-of-Life engine with a handshaked serial load/dump port and an autonomous run controller. A host shifts in a W×H grid, pulses `start` with a generation budget, and the block iterates one generation per clock. It stops early on a still life, then streams the final grid back out. This block replaces the fixed 8x8, mode-pin-driven top level with an FSM-sequenced, size-generic one.

## Interface
- `GRID_WIDTH`, 8, columns per row (≥3)
- `GRID_HEIGHT`, 8, rows (≥3)
- `GEN_WIDTH`, 16, width of generation budget/counter
- Derived: `DATA_SIZE = GRID_WIDTH*GRID_HEIGHT`; cell (r,c) is bit `r*GRID_WIDTH+c`

- `clk` input 1 system clock; everything on rising edge
- `reset` input 1 synchronous, active-high; clears all state
- `data_in` input 1 serial cell value
- `data_in_valid` input 1 `data_in` qualifier
- `start` input 1 run request, sampled in IDLE only
- `gen_count` input GEN_WIDTH generation budget, sampled when `start` accepted
- `data_out` output 1 serial cell value
- `data_out_valid` output 1 `data_out` qualifier
- `busy` output 1 high in LOAD/RUN/DUMP
- `done` output 1 one-cycle pulse at end of DUMP
- `stable` output 1 run ended because next state == current
- `extinct` output 1 final grid all zero
- `gens_run` output GEN_WIDTH generations actually applied

## Operation
- FSM states IDLE, LOAD, RUN, DUMP; reset → IDLE.
- Registers: shift register `sr[DATA_SIZE]`, grid `g[DATA_SIZE]`, load counter, dump counter, `gens_run`, budget latch.
- IDLE:
  - `data_in_valid` → shift bit in and go LOAD with load count 1.
  - Else `start` → latch `gen_count`; clear `stable`, `extinct`, `gens_run`.
    - Budget 0 → go DUMP.
    - Otherwise → go RUN.
  - `data_in_valid` has priority over a simultaneous `start`; that `start` is dropped.
- LOAD:
  - Each valid bit: `sr <= {sr[DATA_SIZE-2:0], data_in}`; invalid cycles hold.
  - On the DATA_SIZE-th bit, `g` takes the shifted value the same edge; go IDLE.
  - First bit received lands in bit DATA_SIZE-1.
  - `start` is ignored.
- RUN: next state computed combinationally from `g`.
  - Rule B3/S23. Neighbours outside the grid are dead; no wrap-around.
  - Each cycle:
    - If next == `g`: set `stable`; `g` unchanged; go DUMP.
    - Else `g <= next`, `gens_run++`. If the incremented value equals the budget, go DUMP.
- DUMP:
  - Load `sr` from `g` on entry.
  - Shift out MSB first for DATA_SIZE consecutive cycles with `data_out_valid=1`.
  - Round-trip bit order equals input order.
  - `extinct` is set on DUMP entry if `g == 0`.
  - After the last bit: `done` pulses for 1 cycle; go IDLE.
- `data_in_valid` and `start` are ignored in RUN and DUMP.
- `stable`, `extinct`, `gens_run` hold until the next accepted `start` or `reset`.
- `gens_run` never exceeds the budget; no wrap.
- A grid is not required to be loaded before `start`. After reset `g = 0`, so a run ends immediately with stable=1, extinct=1, gens_run=0.

## Timing
- Reset values: `data_out=0`, `data_out_valid=0`, `busy=0`, `done=0`, `stable=0`, `extinct=0`, `gens_run=0`, `g=0`, `sr=0`, counters 0.
- `busy` is registered from state: high the cycle after the first valid bit or accepted `start`.
- Load latency: `g` is updated on the edge sampling the last valid bit.
- Run: 1 generation per clock. Run phase lasts min(budget, generations to stability + 1) cycles.
- Dump:
  - `data_out_valid` rises the cycle after the RUN exit edge.
  - No gaps; exactly DATA_SIZE cycles.
  - `done` is in the cycle after the last valid bit, with `busy` low in that same cycle.
- `start` in IDLE → first `data_out_valid`:
  - Budget 0: 1 cycle.
  - Otherwise: run cycles + 1.
- `reset` asserted in any state, including mid-LOAD or mid-DUMP:
  - All outputs return to reset values on that edge.
  - Partial loads are discarded.

## Test plan
- Reset/idle: hold `reset` 2 cycles, then idle 5 → all outputs 0, `busy=0`, no `data_out_valid`.
- Round-trip: load 64-bit pattern 0xA5C3_0F96_1234_FEDC, then `start` with gen_count=0 → 64 valid cycles reproduce the pattern MSB first; gens_run=0, stable=0, extinct=0; `done` 1 cycle.
- Blinker: cells (3,2),(3,3),(3,4) set, gen_count=3 → dump shows (2,3),(3,3),(4,3); gens_run=3, stable=0. Repeat with gap cycles in `data_in_valid` during load → same result.
- Still life / extinction:
  - Block at (1,1),(1,2),(2,1),(2,2), gen_count=100 → gens_run=0, stable=1, grid unchanged.
  - Single cell (0,0) → gens_run=1, stable=1, extinct=1.
- Edge handling: 3-cell vertical line at column 0, rows 0–2, gen_count=1 → (1,0),(1,1) set only; verifies no wrap. Rerun with GRID_WIDTH=5, GRID_HEIGHT=4 parameterisation and 20-bit streams.
- Abort: assert `reset` at dump bit 30 → outputs 0 next cycle. Then `start` with gen_count=5 → stable=1, extinct=1, gens_run=0; `start` held during LOAD has no effect.

Source files
------------

// File: rtl/conway_grid_serial.sv
// conway_grid_serial: a Game-of-Life engine with a size-generic grid.
// The host shifts the grid in serially, then starts a run with a generation
// budget. The engine applies one generation per clock and stops early on a
// still life. It then streams the final grid back out in the order it was
// loaded.
module conway_grid_serial #(
  parameter int GRID_WIDTH  = 8,
  parameter int GRID_HEIGHT = 8,
  parameter int GEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_in,
  input  logic                 data_in_valid,
  input  logic                 start,
  input  logic [GEN_WIDTH-1:0] gen_count,
  output logic                 data_out,
  output logic                 data_out_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 stable,
  output logic                 extinct,
  output logic [GEN_WIDTH-1:0] gens_run
);

  localparam int DATA_SIZE = GRID_WIDTH * GRID_HEIGHT;
  localparam int PAD_W     = GRID_WIDTH + 2;
  localparam int PAD_SIZE  = PAD_W * (GRID_HEIGHT + 2);
  localparam int CNT_WIDTH = $clog2(DATA_SIZE);
  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_SIZE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} state_t;

  state_t state, state_next;

  logic [DATA_SIZE-1:0] sr;
  logic [DATA_SIZE-1:0] sr_shifted;
  logic [DATA_SIZE-1:0] g;
  logic [DATA_SIZE-1:0] g_next;
  logic [PAD_SIZE-1:0]  pad;
  logic [3:0]           nbr;
  logic [CNT_WIDTH-1:0] load_cnt;
  logic [CNT_WIDTH-1:0] dump_cnt;
  logic [GEN_WIDTH-1:0] budget;
  logic [GEN_WIDTH-1:0] gens_inc;

  logic start_ok;
  logic load_last;
  logic run_still;
  logic run_budget_hit;
  logic dump_last;

  assign sr_shifted = {sr[DATA_SIZE-2:0], data_in};
  assign gens_inc   = gens_run + 1'b1;

  // Surround the grid with a dead border so that every cell has eight in-range neighbours.
  always_comb begin
    pad = '0;
    for (int r = 0; r < GRID_HEIGHT; r++) begin
      for (int c = 0; c < GRID_WIDTH; c++) begin
        pad[(r + 1) * PAD_W + c + 1] = g[r * GRID_WIDTH + c];
      end
    end
  end

  // Apply the B3/S23 rule to every cell in parallel to form the next generation.
  always_comb begin
    g_next = '0;
    nbr    = '0;
    for (int r = 0; r < GRID_HEIGHT; r++) begin
      for (int c = 0; c < GRID_WIDTH; c++) begin
        nbr = '0;
        for (int dr = 0; dr < 3; dr++) begin
          for (int dc = 0; dc < 3; dc++) begin
            if (!(dr == 1 && dc == 1)) begin
              nbr = nbr + 4'(pad[(r + dr) * PAD_W + c + dc]);
            end
          end
        end
        g_next[r * GRID_WIDTH + c] = (nbr == 4'd3) || (g[r * GRID_WIDTH + c] && nbr == 4'd2);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the values from before the edge, whatever order the blocks run in.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode, plus one-cycle strobes that the datapath acts on.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path that
    // leaves a signal unassigned would otherwise infer a latch.
    state_next     = state;
    start_ok       = 1'b0;
    load_last      = 1'b0;
    run_still      = 1'b0;
    run_budget_hit = 1'b0;
    dump_last      = 1'b0;
    case (state)
      IDLE: begin
        if (data_in_valid) begin
          state_next = LOAD;
        end else if (start) begin
          start_ok   = 1'b1;
          state_next = (gen_count == '0) ? DUMP : RUN;
        end
      end
      LOAD: begin
        if (data_in_valid && load_cnt == LAST_BIT) begin
          load_last  = 1'b1;
          state_next = IDLE;
        end
      end
      RUN: begin
        if (g_next == g) begin
          run_still  = 1'b1;
          state_next = DUMP;
        end else if (gens_inc == budget) begin
          run_budget_hit = 1'b1;
          state_next     = DUMP;
        end
      end
      DUMP: begin
        if (dump_cnt == LAST_BIT) begin
          dump_last  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy           = (state != IDLE);
  assign data_out_valid = (state == DUMP);
  assign data_out       = (state == DUMP) && sr[DATA_SIZE-1];

  // Datapath: the shift register, the grid, the counters and the run status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the grid and shift registers are cleared on reset, not left
      // undefined. A run started without a prior load must see an all-dead grid.
      sr       <= '0;
      g        <= '0;
      load_cnt <= '0;
      dump_cnt <= '0;
      budget   <= '0;
      gens_run <= '0;
      stable   <= 1'b0;
      extinct  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= dump_last;
      case (state)
        IDLE: begin
          if (data_in_valid) begin
            sr       <= sr_shifted;
            load_cnt <= CNT_WIDTH'(1);
          end else if (start_ok) begin
            budget   <= gen_count;
            gens_run <= '0;
            stable   <= 1'b0;
            extinct  <= (gen_count == '0) && (g == '0);
            sr       <= g;
          end
        end
        LOAD: begin
          if (data_in_valid) begin
            sr <= sr_shifted;
            if (load_last) begin
              g        <= sr_shifted;
              load_cnt <= '0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (run_still) begin
            stable  <= 1'b1;
            sr      <= g;
            extinct <= (g == '0);
          end else begin
            g        <= g_next;
            gens_run <= gens_inc;
            if (run_budget_hit) begin
              sr      <= g_next;
              extinct <= (g_next == '0);
            end
          end
        end
        DUMP: begin
          sr       <= {sr[DATA_SIZE-2:0], 1'b0};
          dump_cnt <= dump_last ? '0 : dump_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
